rv_mem_arbiter: RTL and testbench

- Single-port memory bus arbiter/sequencer for the 5-stage RV32 pipeline.
- Shares one bus between the instruction-fetch port (IF stage) and the data-memory port (MEM stage), one transaction in flight at a time.
- Produces stall requests that the hazard/scheduler logic ORs into stallF and the MEM-stage stall.
- Honours fetch kills on branch-taken flushes.

---
 rtl/rv_mem_arbiter_if.sv | 24 ++
 rtl/rv_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_rv_mem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_mem_arbiter_if.sv
// Memory bus between the arbiter (master) and the single-port memory (slave).
interface rv_mem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();
   logic              bus_req;
   logic              bus_we;
   logic [DW/8-1:0]   bus_wstrb;
   logic [AW-1:0]     bus_addr;
   logic [DW-1:0]     bus_wdata;
   logic              bus_gnt;
   logic              bus_rvalid;
   logic [DW-1:0]     bus_rdata;

   modport master (
      output bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Shares one memory bus between the IF fetch port and the MEM data port,
// one transaction in flight, with fetch-kill and data-run fairness handling.
module rv_mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MAX_DM_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   input  logic              if_kill,
   output logic              if_ack,
   output logic [DW-1:0]     if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [DW/8-1:0]   dm_wstrb,
   input  logic [AW-1:0]     dm_addr,
   input  logic [DW-1:0]     dm_wdata,
   output logic              dm_ack,
   output logic [DW-1:0]     dm_rdata,
   rv_mem_arbiter_if.master  bus,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {StIdle, StAddr, StWait, StResp} state_e;
   typedef enum logic {OwnIf, OwnDm} owner_e;

   localparam logic [3:0] RunMax = 4'(MAX_DM_RUN);

   state_e            state_q;
   owner_e            owner_q;
   logic              kill_q;
   logic [3:0]        dm_run_q;
   logic              if_ack_q;
   logic              dm_ack_q;
   logic [DW-1:0]     if_rdata_q;
   logic [DW-1:0]     dm_rdata_q;
   logic              bus_req_q;
   logic              bus_we_q;
   logic [DW/8-1:0]   bus_wstrb_q;
   logic [AW-1:0]     bus_addr_q;
   logic [DW-1:0]     bus_wdata_q;

   logic if_valid;
   logic if_wins;

   // A killed fetch is not a request; IF only beats DM once DM has had its run.
   assign if_valid = if_req & ~if_kill;
   assign if_wins  = if_valid & (~dm_req | (dm_run_q == RunMax));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= OwnIf;
         kill_q      <= 1'b0;
         dm_run_q    <= 4'd0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_wstrb_q <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         if (if_kill && (owner_q == OwnIf) && (state_q != StIdle)) begin
            kill_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (if_wins) begin
                  owner_q     <= OwnIf;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_wstrb_q <= '1;
                  bus_addr_q  <= if_addr;
                  bus_wdata_q <= '0;
                  dm_run_q    <= 4'd0;
                  state_q     <= StAddr;
               end else if (dm_req) begin
                  owner_q     <= OwnDm;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= dm_we;
                  bus_wstrb_q <= dm_wstrb;
                  bus_addr_q  <= dm_addr;
                  bus_wdata_q <= dm_wdata;
                  if (!if_valid) begin
                     dm_run_q <= 4'd0;
                  end else if (dm_run_q != RunMax) begin
                     dm_run_q <= dm_run_q + 4'd1;
                  end
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (bus.bus_gnt) begin
                  bus_req_q <= 1'b0;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               if (bus.bus_rvalid) begin
                  state_q <= StResp;
                  if (owner_q == OwnDm) begin
                     dm_ack_q   <= 1'b1;
                     dm_rdata_q <= bus.bus_rdata;
                  end else if (!kill_q && !if_kill) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= bus.bus_rdata;
                  end
               end
            end
            StResp: begin
               kill_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // A kill arriving in the response cycle itself still drops the fetch ack.
   assign if_ack    = if_ack_q & ~if_kill;
   assign if_rdata  = if_rdata_q;
   assign dm_ack    = dm_ack_q;
   assign dm_rdata  = dm_rdata_q;
   assign stall_if  = if_req & ~if_ack & ~if_kill;
   assign stall_mem = dm_req & ~dm_ack;

   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_wstrb = bus_wstrb_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: cycle-accurate checks of arbitration,
// latency, fairness, fetch kill, bus stall and mid-transaction reset.
module tb_rv_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, if_ack;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_ack;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        stall_if, stall_mem;

   int total = 0;
   int bad   = 0;

   logic [31:0] seen[$];
   int          n_dm_ack;
   int          n_if_ack;

   rv_mem_arbiter_if #(.AW(32), .DW(32)) bus_if ();

   rv_mem_arbiter #(.AW(32), .DW(32), .MAX_DM_RUN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_kill   (if_kill),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_wstrb  (dm_wstrb),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .bus       (bus_if),
      .stall_if  (stall_if),
      .stall_mem (stall_mem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      if_req = 0; if_kill = 0; if_addr = '0;
      dm_req = 0; dm_we = 0; dm_wstrb = '0; dm_addr = '0; dm_wdata = '0;
      bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = '0;

      // Reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst bus_req", bus_if.bus_req, 0);
      chk("rst bus_addr", bus_if.bus_addr, 0);
      chk("rst bus_wstrb", bus_if.bus_wstrb, 0);
      chk("rst if_ack", if_ack, 0);
      chk("rst dm_ack", dm_ack, 0);
      chk("rst if_rdata", if_rdata, 0);

      // Fetch only: bus_req cycle 1, ack cycle 3
      @(negedge clk); rst = 0; if_req = 1; if_addr = 32'h100; #1;
      chk("t1 c0 stall_if", stall_if, 1);
      chk("t1 c0 bus_req", bus_if.bus_req, 0);
      @(negedge clk); bus_if.bus_gnt = 1; #1;
      chk("t1 c1 bus_req", bus_if.bus_req, 1);
      chk("t1 c1 bus_addr", bus_if.bus_addr, 32'h100);
      chk("t1 c1 bus_we", bus_if.bus_we, 0);
      chk("t1 c1 bus_wstrb", bus_if.bus_wstrb, 4'hF);
      chk("t1 c1 stall_if", stall_if, 1);
      @(negedge clk); bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h13; #1;
      chk("t1 c2 bus_req", bus_if.bus_req, 0);
      chk("t1 c2 stall_if", stall_if, 1);
      @(negedge clk); bus_if.bus_rvalid = 0; #1;
      chk("t1 c3 if_ack", if_ack, 1);
      chk("t1 c3 if_rdata", if_rdata, 32'h13);
      chk("t1 c3 stall_if", stall_if, 0);
      @(negedge clk); if_req = 0; #1;
      chk("t1 c4 if_ack", if_ack, 0);

      // Simultaneous requests: store first, then fetch in ADDR at cycle 5
      @(negedge clk);
      if_req = 1; if_addr = 32'h200;
      dm_req = 1; dm_we = 1; dm_addr = 32'h2000_0004; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
      #1;
      @(negedge clk); bus_if.bus_gnt = 1; #1;
      chk("t2 c1 bus_we", bus_if.bus_we, 1);
      chk("t2 c1 bus_addr", bus_if.bus_addr, 32'h2000_0004);
      chk("t2 c1 bus_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
      chk("t2 c1 stall_mem", stall_mem, 1);
      @(negedge clk); bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = '0; #1;
      @(negedge clk); bus_if.bus_rvalid = 0; #1;
      chk("t2 c3 dm_ack", dm_ack, 1);
      chk("t2 c3 if_ack", if_ack, 0);
      chk("t2 c3 stall_mem", stall_mem, 0);
      @(negedge clk); dm_req = 0; dm_we = 0; #1;
      chk("t2 c4 bus_req", bus_if.bus_req, 0);
      @(negedge clk); bus_if.bus_gnt = 1; #1;
      chk("t2 c5 bus_req", bus_if.bus_req, 1);
      chk("t2 c5 bus_addr", bus_if.bus_addr, 32'h200);
      chk("t2 c5 bus_we", bus_if.bus_we, 0);
      @(negedge clk); bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h1234; #1;
      @(negedge clk); bus_if.bus_rvalid = 0; #1;
      chk("t2 c7 if_ack", if_ack, 1);
      chk("t2 c7 if_rdata", if_rdata, 32'h1234);
      @(negedge clk); if_req = 0; #1;

      // Fairness: both held, gnt/rvalid always high -> D D D D I D
      n_dm_ack = 0; n_if_ack = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if_req = 1; if_addr = 32'h300;
            dm_req = 1; dm_we = 0; dm_addr = 32'h400;
            bus_if.bus_gnt = 1; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h55;
         end
         if (i == 23) begin
            if_req = 0; dm_req = 0;
         end
         #1;
         if (bus_if.bus_req) seen.push_back(bus_if.bus_addr);
         if (dm_ack) n_dm_ack++;
         if (if_ack) n_if_ack++;
      end
      bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0;
      chk("t3 grants", seen.size(), 6);
      if (seen.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3 grant%0d", k), seen[k], (k == 4) ? 32'h300 : 32'h400);
         end
      end
      chk("t3 dm acks", n_dm_ack, 5);
      chk("t3 if acks", n_if_ack, 1);
      chk("t3 if_rdata", if_rdata, 32'h55);

      // Kill during WAIT: response dropped, next fetch normal
      @(negedge clk); if_req = 1; if_addr = 32'h500; #1;
      @(negedge clk); bus_if.bus_gnt = 1; #1;
      chk("t4 c1 bus_req", bus_if.bus_req, 1);
      @(negedge clk); bus_if.bus_gnt = 0; if_kill = 1; if_req = 0; #1;
      chk("t4 c2 stall_if", stall_if, 0);
      @(negedge clk); if_kill = 0; #1;
      @(negedge clk); #1;
      @(negedge clk); bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h66; #1;
      @(negedge clk); bus_if.bus_rvalid = 0; #1;
      chk("t4 c6 if_ack", if_ack, 0);
      @(negedge clk); if_req = 1; if_addr = 32'h600; #1;
      chk("t4 c7 if_ack", if_ack, 0);
      chk("t4 c7 bus_req", bus_if.bus_req, 0);
      @(negedge clk); bus_if.bus_gnt = 1; #1;
      chk("t4 c8 bus_req", bus_if.bus_req, 1);
      chk("t4 c8 bus_addr", bus_if.bus_addr, 32'h600);
      @(negedge clk); bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h77; #1;
      @(negedge clk); bus_if.bus_rvalid = 0; #1;
      chk("t4 c10 if_ack", if_ack, 1);
      chk("t4 c10 if_rdata", if_rdata, 32'h77);
      @(negedge clk); if_req = 0; #1;

      // Load with gnt held low for 5 cycles
      @(negedge clk); dm_req = 1; dm_we = 0; dm_addr = 32'h3000_0008; #1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); #1;
         chk($sformatf("t5 c%0d bus_req", i), bus_if.bus_req, 1);
         chk($sformatf("t5 c%0d bus_addr", i), bus_if.bus_addr, 32'h3000_0008);
      end
      @(negedge clk); bus_if.bus_gnt = 1; #1;
      chk("t5 c6 bus_req", bus_if.bus_req, 1);
      @(negedge clk); bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'hCAFE_F00D; #1;
      chk("t5 c7 dm_ack", dm_ack, 0);
      @(negedge clk); bus_if.bus_rvalid = 0; #1;
      chk("t5 c8 dm_ack", dm_ack, 1);
      chk("t5 c8 dm_rdata", dm_rdata, 32'hCAFE_F00D);
      @(negedge clk); dm_req = 0; #1;

      // Reset while in WAIT
      @(negedge clk); dm_req = 1; dm_addr = 32'h40; #1;
      @(negedge clk); bus_if.bus_gnt = 1; #1;
      @(negedge clk); bus_if.bus_gnt = 0; rst = 1; #1;
      @(negedge clk); rst = 0; dm_req = 0; #1;
      chk("t6 bus_req", bus_if.bus_req, 0);
      chk("t6 bus_addr", bus_if.bus_addr, 0);
      chk("t6 dm_ack", dm_ack, 0);
      chk("t6 dm_rdata", dm_rdata, 0);
      chk("t6 if_rdata", if_rdata, 0);
      @(negedge clk); bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h99; #1;
      @(negedge clk); bus_if.bus_rvalid = 0; #1;
      chk("t6 late dm_ack", dm_ack, 0);
      chk("t6 late bus_req", bus_if.bus_req, 0);
      chk("t6 late dm_rdata", dm_rdata, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
